// File: rtl/adam_aes_decipher_pipelined.sv
// Fully pipelined AES-128 inverse cipher: eleven registered stages, one block per cycle,
// global stall on output backpressure. Uses the encryption-order round-key array as-is.

module adam_aes_inv_round_module #(
  parameter bit IS_FINAL_ROUND = 1'b0
) (
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  output logic [127:0] state_o
);

  localparam logic [7:0] IMC_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse S-box entry: undo the affine map, then invert in GF(2^8) as b^254.
  function automatic logic [7:0] inv_sbox_calc(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] r;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    p = b;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] inv_sbox [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic [7:0] ENTRY = inv_sbox_calc(8'(g));
    assign inv_sbox[g] = ENTRY;
  end

  logic [7:0] ark [16];
  logic [7:0] mix;

  // Byte (r,c) sits at index 4*c+r; InvShiftRows reads row r from column (c-r) mod 4.
  always_comb begin
    ark     = '{default: '0};
    mix     = '0;
    state_o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        ark[4*c+r] = inv_sbox[state_i[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]]
                   ^ round_key_i[127 - 8*(4*c + r) -: 8];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        if (IS_FINAL_ROUND) begin
          state_o[127 - 8*(4*c + r) -: 8] = ark[4*c+r];
        end else begin
          mix = '0;
          for (int unsigned j = 0; j < 4; j++) begin
            mix = mix ^ gf_mul(ark[4*c+j], IMC_COEF[(j + 4 - r) % 4]);
          end
          state_o[127 - 8*(4*c + r) -: 8] = mix;
        end
      end
    end
  end

endmodule

module adam_aes_decipher_pipelined #(
  parameter int unsigned NB_STAGES = 11
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           in_block,
  input  logic [10:0][127:0]     round_keys,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           out_block,
  output logic                   busy
);

  if (NB_STAGES != 11) begin : g_cfg_check
    $error("adam_aes_decipher_pipelined: NB_STAGES must be 11 for AES-128");
  end

  logic [127:0]         data_q    [NB_STAGES];
  logic [127:0]         data_d    [NB_STAGES];
  logic [127:0]         stage_res [NB_STAGES];
  logic [NB_STAGES-1:0] valid_q;
  logic [NB_STAGES-1:0] valid_d;
  logic                 stall;

  assign stage_res[0] = in_block ^ round_keys[NB_STAGES-1];

  for (genvar k = 1; k < NB_STAGES; k++) begin : g_round
    adam_aes_inv_round_module #(
      .IS_FINAL_ROUND(k == NB_STAGES - 1)
    ) u_round (
      .state_i    (data_q[k-1]),
      .round_key_i(round_keys[NB_STAGES-1-k]),
      .state_o    (stage_res[k])
    );
  end

  // Data registers only load behind a valid block; valid bits always shift.
  always_comb begin
    stall   = valid_q[NB_STAGES-1] & ~out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (!stall) begin
      valid_d = {valid_q[NB_STAGES-2:0], in_valid};
      if (in_valid) data_d[0] = stage_res[0];
      for (int unsigned k = 1; k < NB_STAGES; k++) begin
        if (valid_q[k-1]) data_d[k] = stage_res[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < NB_STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < NB_STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = valid_q[NB_STAGES-1];
  assign out_block = data_q[NB_STAGES-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_adam_aes_decipher_pipelined.sv
// Bench for adam_aes_decipher_pipelined: FIPS-197 vector, streaming, backpressure,
// bubbles, mid-flight reset and encrypt/decrypt round trip against a byte-level AES model.

module tb_adam_aes_decipher_pipelined;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_block;
  logic [10:0][127:0] round_keys;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_block;
  logic              busy;

  always #5 clk = ~clk;

  adam_aes_decipher_pipelined #(.NB_STAGES(11)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .round_keys(round_keys),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox     [256];
  logic [7:0] inv_sbox [256];

  localparam logic [7:0] MIX  [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                         '{8'h01, 8'h02, 8'h03, 8'h01},
                                         '{8'h01, 8'h01, 8'h02, 8'h03},
                                         '{8'h03, 8'h01, 8'h01, 8'h02}};
  localparam logic [7:0] IMIX [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                         '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                         '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                         '{8'h0b, 8'h0d, 8'h09, 8'h0e}};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_sbox[sbox[x]] = 8'(x);
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) round_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] kb(input int rnd, input int r, input int c);
    logic [127:0] k;
    k = round_keys[rnd];
    return k[127 - 8*(4*c + r) -: 8];
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ kb(10, r, c);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = inv_sbox[s[r][(c + 4 - r) % 4]] ^ kb(rnd, r, c);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd == 0) s[r][c] = t[r][c];
          else begin
            s[r][c] = 8'h00;
            for (int j = 0; j < 4; j++) s[r][c] = s[r][c] ^ gmul(IMIX[r][j], t[j][c]);
          end
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127 - 8*(4*c + r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ kb(0, r, c);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbox[s[r][(c + r) % 4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd == 10) s[r][c] = t[r][c];
          else begin
            s[r][c] = 8'h00;
            for (int j = 0; j < 4; j++) s[r][c] = s[r][c] ^ gmul(MIX[r][j], t[j][c]);
          end
          s[r][c] = s[r][c] ^ kb(rnd, r, c);
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127 - 8*(4*c + r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus / scoreboard ----------------
  logic [127:0] in_exp;
  logic [127:0] exp_q [$];
  int           out_cyc_q [$];
  int           tcyc;
  int           out_cnt;

  task automatic drive(input logic v, input logic [127:0] b, input logic [127:0] e, input logic r);
    in_valid  = v;
    in_block  = b;
    in_exp    = e;
    out_ready = r;
    @(negedge clk);
    if (out_valid && out_ready) begin
      out_cnt++;
      out_cyc_q.push_back(tcyc);
      if (exp_q.size() == 0) check("unexpected_out", 128'(out_valid), 128'(0));
      else check("out_data", out_block, exp_q.pop_front());
    end
    if (in_valid && in_ready) exp_q.push_back(in_exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic begin_test();
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    out_cyc_q.delete();
    out_cnt = 0;
    tcyc    = 0;
  endtask

  logic [127:0] blk [32];
  logic [127:0] pt_a [100];
  logic [127:0] ct_a [100];
  logic [127:0] held;
  logic [127:0] b;
  logic         v;
  int           idx;
  int           bub_exp [4];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    reset_n    = 1'b1;
    in_valid   = 1'b0;
    in_block   = '0;
    in_exp     = '0;
    out_ready  = 1'b1;
    round_keys = '0;
    tcyc       = 0;
    out_cnt    = 0;
    build_tables();
    #1 reset_n = 1'b0;
    #11;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_out_block", out_block,       128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(1));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 C.1
    expand_key(C1_KEY);
    begin_test();
    for (int c = 0; c < 14; c++) begin
      drive(c == 0, C1_CT, ref_decrypt(C1_CT), 1'b1);
      check("c1_busy",      128'(busy),      128'(c >= 1 && c <= 11));
      check("c1_out_valid", 128'(out_valid), 128'(c == 11));
      if (c == 11) check("c1_plaintext", out_block, C1_PT);
      tick();
    end

    // back-to-back stream
    expand_key(rand128());
    begin_test();
    for (int i = 0; i < 32; i++) blk[i] = rand128();
    for (int c = 0; c < 46; c++) begin
      v = (c < 32);
      b = v ? blk[c] : 128'(0);
      drive(v, b, ref_decrypt(b), 1'b1);
      tick();
    end
    check("stream_count", 128'(out_cnt), 128'(32));
    for (int i = 0; i < out_cyc_q.size(); i++) check("stream_cycle", 128'(out_cyc_q[i]), 128'(11 + i));

    // backpressure
    begin_test();
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      v = (idx < 12);
      b = v ? blk[idx] : 128'(0);
      drive(v, b, ref_decrypt(b), !(c >= 13 && c <= 17));
      if (c >= 13 && c <= 17) begin
        check("bp_in_ready",  128'(in_ready),  128'(0));
        check("bp_out_valid", 128'(out_valid), 128'(1));
        if (c == 13) held = out_block;
        else check("bp_hold", out_block, held);
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    check("bp_count", 128'(out_cnt), 128'(12));

    // bubbles
    begin_test();
    for (int c = 0; c < 25; c++) begin
      v = (c == 0 || c == 2 || c == 3 || c == 7);
      b = v ? blk[c] : 128'(0);
      drive(v, b, ref_decrypt(b), 1'b1);
      tick();
    end
    bub_exp = '{11, 13, 14, 18};
    check("bub_count", 128'(out_cnt), 128'(4));
    for (int i = 0; i < out_cyc_q.size() && i < 4; i++)
      check("bub_cycle", 128'(out_cyc_q[i]), 128'(bub_exp[i]));

    // reset mid-flight
    begin_test();
    for (int c = 0; c < 6; c++) begin
      v = (c < 5);
      b = v ? blk[c] : 128'(0);
      drive(v, b, ref_decrypt(b), 1'b1);
      tick();
    end
    #2 reset_n = 1'b0;
    #1;
    check("mrst_out_valid", 128'(out_valid), 128'(0));
    check("mrst_busy",      128'(busy),      128'(0));
    check("mrst_out_block", out_block,       128'(0));
    check("mrst_in_ready",  128'(in_ready),  128'(1));
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, '0, '0, 1'b1);
      tick();
    end
    check("mrst_no_output", 128'(out_cnt), 128'(0));
    check("mrst_idle_busy", 128'(busy),    128'(0));

    // round trip with random backpressure
    expand_key(rand128());
    begin_test();
    for (int i = 0; i < 100; i++) begin
      pt_a[i] = rand128();
      ct_a[i] = ref_encrypt(pt_a[i]);
    end
    idx = 0;
    for (int c = 0; c < 600 && out_cnt < 100; c++) begin
      v = (idx < 100);
      drive(v, v ? ct_a[idx] : 128'(0), v ? pt_a[idx] : 128'(0), $urandom_range(0, 3) != 0);
      if (in_valid && in_ready) idx++;
      tick();
    end
    check("rt_count", 128'(out_cnt), 128'(100));
    check("rt_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adam_aes_decipher_pipelined.md
Name: adam_aes_decipher_pipelined

Overview:
- Fully pipelined AES-128 inverse cipher; the decryption counterpart of the team's pipelined AES encipher in the aes_core peripheral.
- Accepts one ciphertext block per cycle under a valid/ready handshake and returns plaintext 11 cycles later, in order.
- Supports output backpressure via a global pipeline stall.
- Consumes the same encryption-order round-key array (round_keys[0..10]) that the key expander already produces for the encipher.

Parameters:
- NB_STAGES, 11, number of registered pipeline stages; fixed for AES-128. Any other value is a configuration error and must fail elaboration.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ciphertext block present on in_block.
- in_ready  out  1  block accepts input this cycle.
- in_block  in  128  ciphertext, byte 0 in bits [127:120].
- round_keys  in  11x128  encryption round keys; index 0 is the cipher key, index 10 is the last.
- out_valid  out  1  plaintext present on out_block.
- out_ready  in  1  downstream accepts output.
- out_block  out  128  plaintext.
- busy  out  1  at least one stage holds a valid block.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All stage valid bits clear; all stage data registers clear to 0.
  - Outputs: out_valid=0, out_block=0, busy=0, in_ready=1.
  - Reset asserted mid-operation discards all in-flight blocks; nothing is emitted after release.
- Stage functions (each stage's input is the previous stage's register):
  - S0 = in_block ^ round_keys[10].
  - S1..S9 (stage k uses rk = round_keys[10-k]): InvShiftRows, InvSubBytes, ^rk, InvMixColumns.
  - S10: InvShiftRows, InvSubBytes, ^round_keys[0]; no InvMixColumns.
  - Inverse-round logic comes from the combinational adam_aes_inv_round_module, with parameter IS_FINAL_ROUND=1 for S10.
- Data path:
  - out_block = S10 register; out_valid = S10 valid bit.
- Stall and handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - When stall=0, every stage register and its valid bit advance by one stage on the clock edge.
  - S0 valid loads (in_valid & in_ready).
  - When stall=1, all stages hold; in_block is not sampled.
- Latency: a block accepted at edge T appears with out_valid=1 after edge T+10 (visible in cycle T+11), assuming no stall.
- Throughput: 1 block/cycle sustained when out_ready=1.
- Bubbles: idle input cycles propagate as valid=0 holes; output order always equals input order.
- Transfer rule: an output transfer occurs when out_valid & out_ready. If out_ready=1 and S9 is invalid, out_valid drops next cycle.
- Simultaneous accept and emit in one cycle is legal and is the steady state.
- busy = OR of all 11 valid bits.
- round_keys must remain stable while busy=1. Changing them mid-flight gives undefined plaintext but must not corrupt the valid bits or ordering.
- Data registers may be clock-gated on their valid bit; valid bits themselves must never be gated.
- No internal FSM beyond the valid shift chain. The stall condition is the only control state: there is no IDLE/DONE handshake, and no start pulse is required.

Test Plan:
- FIPS-197 C.1 single block:
  - Keys expanded from 000102030405060708090a0b0c0d0e0f.
  - in_block 69c4e0d86a7b0430d8cdb78070b4c55a accepted at cycle 0.
  - Expect out_valid rising in cycle 11 with out_block 00112233445566778899aabbccddeeff, busy=1 for cycles 1-11, then busy=0.
- Back-to-back stream:
  - 32 random blocks in consecutive cycles, out_ready=1.
  - Expect 32 consecutive out_valid cycles starting at cycle 11, each equal to the reference decrypt, in order.
- Backpressure:
  - During a 12-block stream, hold out_ready=0 for 5 cycles while out_valid=1.
  - Expect in_ready=0 and out_block stable for those cycles, no loss or duplication, and total output count 12.
- Bubbles:
  - Inputs valid on cycles 0, 2, 3, 7.
  - Expect outputs on cycles 11, 13, 14, 18 with the matching plaintexts.
- Reset mid-flight:
  - Accept 5 blocks, then pulse reset_n low at cycle 6 (asynchronous, between edges).
  - Expect out_valid=0, busy=0, out_block=0 immediately, and no outputs afterwards.
- Round trip:
  - Feed the encipher output into this block with the same keys, over 100 random plaintexts.
  - Expect out_block to equal the original plaintext for every block.
